// File: rtl/axis_demux.sv
// axis_demux: 1:2 AXI-Stream router with packet-atomic route selection.
// Ports: clk/reset, s_axis_* slave in, sel_in route, m0/m1_axis_* outs, busy.
module axis_demux #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [width-1:0] s_axis_tdata,
  input  logic             s_axis_tlast,
  input  logic             sel_in,
  output logic             m0_axis_tvalid,
  input  logic             m0_axis_tready,
  output logic [width-1:0] m0_axis_tdata,
  output logic             m0_axis_tlast,
  output logic             m1_axis_tvalid,
  input  logic             m1_axis_tready,
  output logic [width-1:0] m1_axis_tdata,
  output logic             m1_axis_tlast,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } state_t;

  state_t state;
  logic   route;
  logic   acc;
  logic   start;

  assign s_axis_tready = route
    ? (!m1_axis_tvalid | m1_axis_tready)
    : (!m0_axis_tvalid | m0_axis_tready);

  assign acc   = s_axis_tvalid & s_axis_tready;
  // first beat of a multi-beat packet: route must not move under it
  assign start = acc & !s_axis_tlast;
  assign busy  = (state == PKT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      route <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (!start)
            route <= sel_in;
          if (start)
            state <= PKT;
        end
        PKT: begin
          if (acc && s_axis_tlast)
            state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_axis_tvalid <= 1'b0;
      m0_axis_tdata  <= '0;
      m0_axis_tlast  <= 1'b0;
    end else if (acc && !route) begin
      m0_axis_tvalid <= 1'b1;
      m0_axis_tdata  <= s_axis_tdata;
      m0_axis_tlast  <= s_axis_tlast;
    end else if (m0_axis_tvalid && m0_axis_tready) begin
      m0_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m1_axis_tvalid <= 1'b0;
      m1_axis_tdata  <= '0;
      m1_axis_tlast  <= 1'b0;
    end else if (acc && route) begin
      m1_axis_tvalid <= 1'b1;
      m1_axis_tdata  <= s_axis_tdata;
      m1_axis_tlast  <= s_axis_tlast;
    end else if (m1_axis_tvalid && m1_axis_tready) begin
      m1_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_demux.sv
// tb_axis_demux: scoreboard bench for axis_demux.
// Expected beats queued per output on acceptance, popped on output handshake.
module tb_axis_demux;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [W-1:0] s_axis_tdata = '0;
  logic         s_axis_tlast = 1'b0;
  logic         sel_in = 1'b0;
  logic         m0_axis_tvalid;
  logic         m0_axis_tready = 1'b1;
  logic [W-1:0] m0_axis_tdata;
  logic         m0_axis_tlast;
  logic         m1_axis_tvalid;
  logic         m1_axis_tready = 1'b1;
  logic [W-1:0] m1_axis_tdata;
  logic         m1_axis_tlast;
  logic         busy;

  int total = 0;
  int bad = 0;
  logic [W:0] q0[$];
  logic [W:0] q1[$];
  logic [W:0] e0, e1;

  axis_demux #(.width(W)) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .sel_in(sel_in),
    .m0_axis_tvalid(m0_axis_tvalid), .m0_axis_tready(m0_axis_tready),
    .m0_axis_tdata(m0_axis_tdata), .m0_axis_tlast(m0_axis_tlast),
    .m1_axis_tvalid(m1_axis_tvalid), .m1_axis_tready(m1_axis_tready),
    .m1_axis_tdata(m1_axis_tdata), .m1_axis_tlast(m1_axis_tlast),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      if (m0_axis_tvalid && m0_axis_tready) begin
        total++;
        if (q0.size() == 0) begin
          bad++;
          $display("FAIL m0_spurious got=%h want=none", m0_axis_tdata);
        end else begin
          e0 = q0.pop_front();
          if ({m0_axis_tlast, m0_axis_tdata} !== e0) begin
            bad++;
            $display("FAIL m0_beat got=%b/%h want=%b/%h",
                     m0_axis_tlast, m0_axis_tdata, e0[W], e0[W-1:0]);
          end
        end
      end
      if (m1_axis_tvalid && m1_axis_tready) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $display("FAIL m1_spurious got=%h want=none", m1_axis_tdata);
        end else begin
          e1 = q1.pop_front();
          if ({m1_axis_tlast, m1_axis_tdata} !== e1) begin
            bad++;
            $display("FAIL m1_beat got=%b/%h want=%b/%h",
                     m1_axis_tlast, m1_axis_tdata, e1[W], e1[W-1:0]);
          end
        end
      end
    end
  end

  // Present a beat from posedge+1, wait for acceptance, return at posedge+1
  // after the accepting edge with tvalid still high.
  task automatic send(input logic [W-1:0] d, input logic l, input logic dst);
    logic ok;
    ok = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout got=stalled want=accept data=%h", d);
    end else if (dst) begin
      q1.push_back({l, d});
    end else begin
      q0.push_back({l, d});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    total++;
    if ({m0_axis_tvalid, m1_axis_tvalid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL rst_flags got=%b want=000",
               {m0_axis_tvalid, m1_axis_tvalid, busy});
    end
    total++;
    if ({m0_axis_tdata, m0_axis_tlast, m1_axis_tdata, m1_axis_tlast} !== '0) begin
      bad++;
      $display("FAIL rst_data got=%h/%h want=0/0", m0_axis_tdata, m1_axis_tdata);
    end
    total++;
    if (s_axis_tready !== 1'b1) begin
      bad++;
      $display("FAIL rst_ready got=%b want=1", s_axis_tready);
    end
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_basic;
    logic [W-1:0] a[3];
    a[0] = 16'hA001; a[1] = 16'hA002; a[2] = 16'hA003;
    sel_in = 1'b0;
    m0_axis_tready = 1'b1;
    m1_axis_tready = 1'b1;
    idle(1);
    for (int k = 0; k < 3; k++) begin
      send(a[k], k == 2, 1'b0);
      total++;
      if ({m0_axis_tvalid, m0_axis_tlast, m0_axis_tdata, m1_axis_tvalid}
          !== {1'b1, k == 2, a[k], 1'b0}) begin
        bad++;
        $display("FAIL basic_out%0d got=%b/%b/%h m1v=%b want=1/%b/%h m1v=0",
                 k, m0_axis_tvalid, m0_axis_tlast, m0_axis_tdata,
                 m1_axis_tvalid, k == 2, a[k]);
      end
    end
    idle(2);
  endtask

  task automatic test_mid_toggle;
    sel_in = 1'b0;
    idle(1);
    for (int k = 0; k < 4; k++) begin
      send(16'hB000 + W'(k), k == 3, 1'b0);
      if (k == 0) sel_in = 1'b1;
      total++;
      if (busy !== (k != 3)) begin
        bad++;
        $display("FAIL toggle_busy%0d got=%b want=%b", k, busy, k != 3);
      end
    end
    idle(1);
    for (int k = 0; k < 2; k++) begin
      send(16'hC000 + W'(k), k == 1, 1'b1);
      total++;
      if (busy !== (k == 0)) begin
        bad++;
        $display("FAIL pkt2_busy%0d got=%b want=%b", k, busy, k == 0);
      end
    end
    idle(2);
  endtask

  task automatic test_backpressure;
    sel_in = 1'b0;
    idle(1);
    m0_axis_tready = 1'b0;
    send(16'hD001, 1'b0, 1'b0);
    s_axis_tdata = 16'hD002;
    s_axis_tlast = 1'b1;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({s_axis_tready, m0_axis_tvalid, m0_axis_tdata} !== {2'b01, 16'hD001}) begin
        bad++;
        $display("FAIL bp_hold got=rdy%b v%b %h want=rdy0 v1 d001",
                 s_axis_tready, m0_axis_tvalid, m0_axis_tdata);
      end
    end
    @(posedge clk); #1;
    m0_axis_tready = 1'b1;
    send(16'hD002, 1'b1, 1'b0);
    idle(3);
  endtask

  task automatic test_independent_drain;
    sel_in = 1'b0;
    m0_axis_tready = 1'b0;
    idle(1);
    send(16'h1234, 1'b1, 1'b0);
    sel_in = 1'b1;
    idle(1);
    m1_axis_tready = 1'b1;
    send(16'hBEEF, 1'b1, 1'b1);
    total++;
    if ({m1_axis_tvalid, m1_axis_tdata, m0_axis_tvalid, m0_axis_tdata}
        !== {1'b1, 16'hBEEF, 1'b1, 16'h1234}) begin
      bad++;
      $display("FAIL drain got=m1 %b/%h m0 %b/%h want=m1 1/beef m0 1/1234",
               m1_axis_tvalid, m1_axis_tdata, m0_axis_tvalid, m0_axis_tdata);
    end
    s_axis_tvalid = 1'b0;
    m0_axis_tready = 1'b1;
    idle(3);
  endtask

  task automatic test_single_beats;
    logic s;
    m0_axis_tready = 1'b1;
    m1_axis_tready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      s = k[0];
      sel_in = s;
      idle(1);
      send(16'h5000 + W'(k), 1'b1, s);
      total++;
      if (busy !== 1'b0) begin
        bad++;
        $display("FAIL single_busy%0d got=%b want=0", k, busy);
      end
      total++;
      if ((s ? {m1_axis_tvalid, m1_axis_tlast} : {m0_axis_tvalid, m0_axis_tlast})
          !== 2'b11) begin
        bad++;
        $display("FAIL single_out%0d got=m0 %b m1 %b want=m%0d valid+last",
                 k, m0_axis_tvalid, m1_axis_tvalid, s);
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid_packet;
    sel_in = 1'b0;
    idle(1);
    send(16'hE001, 1'b0, 1'b0);
    send(16'hE002, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst_busy got=%b want=1", busy);
    end
    s_axis_tvalid = 1'b0;
    sel_in = 1'b1;
    reset = 1'b0;
    #1;
    total++;
    if ({m0_axis_tvalid, m1_axis_tvalid, busy} !== 3'b000) begin
      bad++;
      $display("FAIL mid_rst got=%b want=000",
               {m0_axis_tvalid, m1_axis_tvalid, busy});
    end
    q0.delete();
    q1.delete();
    @(posedge clk); #1;
    sel_in = 1'b0;
    reset = 1'b1;
    idle(1);
    send(16'hF001, 1'b0, 1'b0);
    total++;
    if ({m0_axis_tvalid, m0_axis_tdata, m1_axis_tvalid} !== {1'b1, 16'hF001, 1'b0}) begin
      bad++;
      $display("FAIL post_rst got=m0 %b/%h m1 %b want=m0 1/f001 m1 0",
               m0_axis_tvalid, m0_axis_tdata, m1_axis_tvalid);
    end
    send(16'hF002, 1'b1, 1'b0);
    idle(3);
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mid_toggle;
    test_backpressure;
    test_independent_drain;
    test_single_beats;
    test_reset_mid_packet;
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL leftover got=%0d/%0d want=0/0", q0.size(), q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
